// File: rtl/pipe_ctrl_unit.sv
// ============================================================================
// Module   : pipe_ctrl_unit
// Brief    : Pipelined control unit for a 5-stage MIPS core: opcode decode,
//            ID/EX, EX/MEM, MEM/WB control registers, load-use stall, branch
//            and jump flush, saturating debug counters.
//            Optional macro CTRL_ILLEGAL_OP_EN enables the sticky illegal_op flag.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module pipe_ctrl_unit #(
  parameter int RA_W  = 5,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             id_valid,
  input  logic [5:0]       id_op,
  input  logic [RA_W-1:0]  id_rs,
  input  logic [RA_W-1:0]  id_rt,
  input  logic             mem_branch_taken,
  output logic             stall,
  output logic             flush_ifid,
  output logic [3:0]       ex_ctrl,
  output logic [RA_W-1:0]  ex_rt,
  output logic [3:0]       mem_ctrl,
  output logic [1:0]       wb_ctrl,
  output logic             ex_valid,
  output logic             mem_valid,
  output logic             wb_valid,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt,
  output logic             illegal_op
);

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_ANDI  = 6'b001100;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_SLTI  = 6'b001010;
  localparam logic [5:0] OP_J     = 6'b000010;

  logic [3:0] dec_ex;
  logic [3:0] dec_m;
  logic [1:0] dec_wb;
  logic       uses_rs;
  logic       uses_rt;

  // ID/EX
  logic [3:0]      ex_ctrl_q,  ex_ctrl_d;
  logic [3:0]      ex_m_q,     ex_m_d;
  logic [1:0]      ex_wb_q,    ex_wb_d;
  logic [RA_W-1:0] ex_rt_q,    ex_rt_d;
  logic            ex_valid_q, ex_valid_d;
  // EX/MEM
  logic [3:0]      mem_ctrl_q,  mem_ctrl_d;
  logic [1:0]      mem_wb_q,    mem_wb_d;
  logic            mem_valid_q, mem_valid_d;
  // MEM/WB
  logic [1:0]      wb_ctrl_q,  wb_ctrl_d;
  logic            wb_valid_q, wb_valid_d;

  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;

  logic hazard;
  logic jump_flush;
  logic id_load;

  always_comb begin
    dec_ex  = 4'b0000;
    dec_m   = 4'b0000;
    dec_wb  = 2'b00;
    uses_rs = (id_op != OP_J);
    uses_rt = 1'b0;
    case (id_op)
      OP_RTYPE: begin dec_ex = 4'b1100; dec_wb = 2'b10; uses_rt = 1'b1; end
      OP_LW:    begin dec_ex = 4'b0001; dec_m = 4'b0100; dec_wb = 2'b11; end
      OP_SW:    begin dec_ex = 4'b0001; dec_m = 4'b0010; uses_rt = 1'b1; end
      OP_BEQ:   begin dec_ex = 4'b0010; dec_m = 4'b1000; uses_rt = 1'b1; end
      OP_ADDI, OP_ANDI, OP_ORI, OP_SLTI:
                begin dec_ex = 4'b0101; dec_wb = 2'b10; end
      OP_J:     begin dec_ex = 4'b0110; dec_m = 4'b0001; end
      default:  ;
    endcase
  end

  always_comb begin
    hazard = id_valid & ex_valid_q & ex_m_q[2] & (ex_rt_q != '0) &
             (((ex_rt_q == id_rs) & uses_rs) | ((ex_rt_q == id_rt) & uses_rt));
    jump_flush = id_valid & (id_op == OP_J) & ~hazard;
    // A taken branch in MEM overrides both the load-use stall and the jump
    stall      = ~rst & hazard & ~mem_branch_taken;
    flush_ifid = ~rst & (mem_branch_taken | jump_flush);
    id_load    = id_valid & ~hazard & ~mem_branch_taken;
  end

  always_comb begin
    ex_ctrl_d  = id_load ? dec_ex : 4'b0000;
    ex_m_d     = id_load ? dec_m  : 4'b0000;
    ex_wb_d    = id_load ? dec_wb : 2'b00;
    ex_rt_d    = id_load ? id_rt  : '0;
    ex_valid_d = id_load;

    mem_ctrl_d  = mem_branch_taken ? 4'b0000 : ex_m_q;
    mem_wb_d    = mem_branch_taken ? 2'b00   : ex_wb_q;
    mem_valid_d = ~mem_branch_taken & ex_valid_q;

    wb_ctrl_d  = mem_wb_q;
    wb_valid_d = mem_valid_q;

    stall_cnt_d = stall_cnt_q;
    if (stall && (stall_cnt_q != '1))
      stall_cnt_d = stall_cnt_q + 1'b1;
    flush_cnt_d = flush_cnt_q;
    if (flush_ifid && (flush_cnt_q != '1))
      flush_cnt_d = flush_cnt_q + 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ex_ctrl_q   <= 4'b0000;
      ex_m_q      <= 4'b0000;
      ex_wb_q     <= 2'b00;
      ex_rt_q     <= '0;
      ex_valid_q  <= 1'b0;
      mem_ctrl_q  <= 4'b0000;
      mem_wb_q    <= 2'b00;
      mem_valid_q <= 1'b0;
      wb_ctrl_q   <= 2'b00;
      wb_valid_q  <= 1'b0;
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      ex_ctrl_q   <= ex_ctrl_d;
      ex_m_q      <= ex_m_d;
      ex_wb_q     <= ex_wb_d;
      ex_rt_q     <= ex_rt_d;
      ex_valid_q  <= ex_valid_d;
      mem_ctrl_q  <= mem_ctrl_d;
      mem_wb_q    <= mem_wb_d;
      mem_valid_q <= mem_valid_d;
      wb_ctrl_q   <= wb_ctrl_d;
      wb_valid_q  <= wb_valid_d;
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

`ifdef CTRL_ILLEGAL_OP_EN
  logic op_legal;
  logic illegal_op_q, illegal_op_d;

  always_comb begin
    case (id_op)
      OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_ADDI,
      OP_ANDI, OP_ORI, OP_SLTI, OP_J: op_legal = 1'b1;
      default:                        op_legal = 1'b0;
    endcase
    illegal_op_d = illegal_op_q | (id_valid & ~op_legal & ~stall);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) illegal_op_q <= 1'b0;
    else     illegal_op_q <= illegal_op_d;
  end

  assign illegal_op = illegal_op_q;
`else
  assign illegal_op = 1'b0;
`endif

  assign ex_ctrl   = ex_ctrl_q;
  assign ex_rt     = ex_rt_q;
  assign ex_valid  = ex_valid_q;
  assign mem_ctrl  = mem_ctrl_q;
  assign mem_valid = mem_valid_q;
  assign wb_ctrl   = wb_ctrl_q;
  assign wb_valid  = wb_valid_q;
  assign stall_cnt = stall_cnt_q;
  assign flush_cnt = flush_cnt_q;

endmodule

`default_nettype wire

// File: tb/tb_pipe_ctrl_unit.sv
// ============================================================================
// Module   : tb_pipe_ctrl_unit
// Brief    : Directed self-checking bench for pipe_ctrl_unit (CNT_W=2).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_pipe_ctrl_unit;

  localparam int RA_W  = 5;
  localparam int CNT_W = 2;

  localparam logic [5:0] OP_R    = 6'b000000;
  localparam logic [5:0] OP_LW   = 6'b100011;
  localparam logic [5:0] OP_SW   = 6'b101011;
  localparam logic [5:0] OP_BEQ  = 6'b000100;
  localparam logic [5:0] OP_ADDI = 6'b001000;
  localparam logic [5:0] OP_ORI  = 6'b001101;
  localparam logic [5:0] OP_J    = 6'b000010;
  localparam logic [5:0] OP_BAD  = 6'b111111;

`ifdef CTRL_ILLEGAL_OP_EN
  localparam logic ILL_EXP = 1'b1;
`else
  localparam logic ILL_EXP = 1'b0;
`endif

  logic             clk = 1'b0;
  logic             rst;
  logic             id_valid;
  logic [5:0]       id_op;
  logic [RA_W-1:0]  id_rs;
  logic [RA_W-1:0]  id_rt;
  logic             mem_branch_taken;
  logic             stall;
  logic             flush_ifid;
  logic [3:0]       ex_ctrl;
  logic [RA_W-1:0]  ex_rt;
  logic [3:0]       mem_ctrl;
  logic [1:0]       wb_ctrl;
  logic             ex_valid;
  logic             mem_valid;
  logic             wb_valid;
  logic [CNT_W-1:0] stall_cnt;
  logic [CNT_W-1:0] flush_cnt;
  logic             illegal_op;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  pipe_ctrl_unit #(.RA_W(RA_W), .CNT_W(CNT_W)) u_dut (
    .clk              (clk),
    .rst              (rst),
    .id_valid         (id_valid),
    .id_op            (id_op),
    .id_rs            (id_rs),
    .id_rt            (id_rt),
    .mem_branch_taken (mem_branch_taken),
    .stall            (stall),
    .flush_ifid       (flush_ifid),
    .ex_ctrl          (ex_ctrl),
    .ex_rt            (ex_rt),
    .mem_ctrl         (mem_ctrl),
    .wb_ctrl          (wb_ctrl),
    .ex_valid         (ex_valid),
    .mem_valid        (mem_valid),
    .wb_valid         (wb_valid),
    .stall_cnt        (stall_cnt),
    .flush_cnt        (flush_cnt),
    .illegal_op       (illegal_op)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Present an ID-stage instruction and let combinational outputs settle
  task automatic drive(input logic v, input logic [5:0] op, input logic [RA_W-1:0] rs,
                       input logic [RA_W-1:0] rt, input logic br);
    id_valid         = v;
    id_op            = op;
    id_rs            = rs;
    id_rt            = rt;
    mem_branch_taken = br;
    #1;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    drive(1'b0, OP_R, 5'd0, 5'd0, 1'b0);
  endtask

  initial begin
    rst = 1'b1;
    drive(1'b1, OP_J, 5'd0, 5'd0, 1'b1);
    #2;
    chk("rst_stall", {31'd0, stall}, 32'd0);
    chk("rst_flush", {31'd0, flush_ifid}, 32'd0);
    chk("rst_ex_valid", {31'd0, ex_valid}, 32'd0);
    chk("rst_cnt", {28'd0, stall_cnt, flush_cnt}, 32'd0);
    tick();
    tick();
    idle();
    rst = 1'b0;
    #1;

    // Straight-line flow: add, lw, sw, ori
    drive(1'b1, OP_R, 5'd1, 5'd2, 1'b0);
    chk("sl_add_stall", {31'd0, stall}, 32'd0);
    tick();
    chk("sl_add_ex", {28'd0, ex_ctrl}, 32'hC);
    chk("sl_add_exv", {31'd0, ex_valid}, 32'd1);
    drive(1'b1, OP_LW, 5'd3, 5'd4, 1'b0);
    tick();
    chk("sl_lw_ex", {28'd0, ex_ctrl}, 32'h1);
    chk("sl_lw_rt", {27'd0, ex_rt}, 32'd4);
    drive(1'b1, OP_SW, 5'd5, 5'd6, 1'b0);
    chk("sl_sw_stall", {31'd0, stall}, 32'd0);
    tick();
    chk("sl_sw_ex", {28'd0, ex_ctrl}, 32'h1);
    chk("sl_lw_mem", {28'd0, mem_ctrl}, 32'h4);
    chk("sl_add_wb", {30'd0, wb_ctrl}, 32'h2);
    drive(1'b1, OP_ORI, 5'd7, 5'd9, 1'b0);
    tick();
    chk("sl_ori_ex", {28'd0, ex_ctrl}, 32'h5);
    chk("sl_lw_wb", {30'd0, wb_ctrl}, 32'h3);
    idle();
    tick();
    chk("sl_idle_exv", {31'd0, ex_valid}, 32'd0);
    chk("sl_idle_ex", {28'd0, ex_ctrl}, 32'h0);
    chk("sl_sw_wb", {30'd0, wb_ctrl}, 32'h0);
    chk("sl_sw_wbv", {31'd0, wb_valid}, 32'd1);
    tick();
    chk("sl_ori_wb", {30'd0, wb_ctrl}, 32'h2);
    tick();
    chk("sl_end_wbv", {31'd0, wb_valid}, 32'd0);
    chk("sl_no_stall", {30'd0, stall_cnt}, 32'd0);

    // Load-use via rs
    drive(1'b1, OP_LW, 5'd1, 5'd8, 1'b0);
    tick();
    drive(1'b1, OP_R, 5'd8, 5'd2, 1'b0);
    chk("lu_stall", {31'd0, stall}, 32'd1);
    chk("lu_flush", {31'd0, flush_ifid}, 32'd0);
    tick();
    chk("lu_bubble_v", {31'd0, ex_valid}, 32'd0);
    chk("lu_bubble_c", {28'd0, ex_ctrl}, 32'h0);
    chk("lu_lw_mem", {28'd0, mem_ctrl}, 32'h4);
    chk("lu_cnt", {30'd0, stall_cnt}, 32'd1);
    chk("lu_stall_gone", {31'd0, stall}, 32'd0);
    tick();
    chk("lu_add_ex", {28'd0, ex_ctrl}, 32'hC);
    chk("lu_add_exv", {31'd0, ex_valid}, 32'd1);

    // lw to $0 never stalls
    drive(1'b1, OP_LW, 5'd1, 5'd0, 1'b0);
    tick();
    drive(1'b1, OP_R, 5'd0, 5'd0, 1'b0);
    chk("lu0_stall", {31'd0, stall}, 32'd0);
    tick();
    chk("lu0_add_ex", {28'd0, ex_ctrl}, 32'hC);

    // addi does not read rt; sw does
    drive(1'b1, OP_LW, 5'd1, 5'd8, 1'b0);
    tick();
    drive(1'b1, OP_ADDI, 5'd1, 5'd8, 1'b0);
    chk("lu_addi_rt", {31'd0, stall}, 32'd0);
    tick();
    drive(1'b1, OP_LW, 5'd1, 5'd8, 1'b0);
    tick();
    drive(1'b1, OP_SW, 5'd1, 5'd8, 1'b0);
    chk("lu_sw_rt", {31'd0, stall}, 32'd1);
    tick();
    chk("lu_sw_cnt", {30'd0, stall_cnt}, 32'd2);

    // Branch flush overrides a pending load-use hazard
    drive(1'b1, OP_BEQ, 5'd1, 5'd2, 1'b0);
    tick();
    drive(1'b1, OP_LW, 5'd3, 5'd8, 1'b0);
    tick();
    drive(1'b1, OP_LW, 5'd8, 5'd9, 1'b1);
    chk("br_mem", {28'd0, mem_ctrl}, 32'h8);
    chk("br_stall", {31'd0, stall}, 32'd0);
    chk("br_flush", {31'd0, flush_ifid}, 32'd1);
    tick();
    chk("br_exv", {31'd0, ex_valid}, 32'd0);
    chk("br_memv", {31'd0, mem_valid}, 32'd0);
    chk("br_wbv", {31'd0, wb_valid}, 32'd1);
    chk("br_fcnt", {30'd0, flush_cnt}, 32'd1);
    chk("br_scnt", {30'd0, stall_cnt}, 32'd2);

    // Jump
    drive(1'b1, OP_J, 5'd0, 5'd0, 1'b0);
    chk("j_flush", {31'd0, flush_ifid}, 32'd1);
    chk("j_stall", {31'd0, stall}, 32'd0);
    tick();
    chk("j_ex", {28'd0, ex_ctrl}, 32'h6);
    chk("j_fcnt", {30'd0, flush_cnt}, 32'd2);
    idle();
    chk("j_idle_flush", {31'd0, flush_ifid}, 32'd0);
    tick();
    chk("j_mem", {28'd0, mem_ctrl}, 32'h1);

    // Saturation: three more stalls (5 total), two more flushes (4 total)
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, OP_LW, 5'd1, 5'd8, 1'b0);
      tick();
      drive(1'b1, OP_R, 5'd8, 5'd3, 1'b0);
      tick();
    end
    chk("sat_stall", {30'd0, stall_cnt}, 32'd3);
    for (int i = 0; i < 2; i++) begin
      drive(1'b1, OP_J, 5'd0, 5'd0, 1'b0);
      tick();
    end
    chk("sat_flush", {30'd0, flush_cnt}, 32'd3);

    // Illegal opcode
    idle();
    chk("ill_pre", {31'd0, illegal_op}, 32'd0);
    drive(1'b1, OP_BAD, 5'd1, 5'd2, 1'b0);
    tick();
    chk("ill_flag", {31'd0, illegal_op}, {31'd0, ILL_EXP});
    chk("ill_ex", {28'd0, ex_ctrl}, 32'h0);
    chk("ill_exv", {31'd0, ex_valid}, 32'd1);
    idle();
    tick();
    tick();
    chk("ill_hold", {31'd0, illegal_op}, {31'd0, ILL_EXP});
    chk("ill_mem", {28'd0, mem_ctrl}, 32'h0);

    // Mid-pipeline async reset with lw in EX
    drive(1'b1, OP_LW, 5'd1, 5'd8, 1'b0);
    tick();
    drive(1'b1, OP_R, 5'd8, 5'd8, 1'b1);
    rst = 1'b1;
    #1;
    chk("mrst_ex", {28'd0, ex_ctrl}, 32'h0);
    chk("mrst_exv", {31'd0, ex_valid}, 32'd0);
    chk("mrst_rt", {27'd0, ex_rt}, 32'd0);
    chk("mrst_stall", {31'd0, stall}, 32'd0);
    chk("mrst_flush", {31'd0, flush_ifid}, 32'd0);
    chk("mrst_cnt", {28'd0, stall_cnt, flush_cnt}, 32'd0);
    chk("mrst_ill", {31'd0, illegal_op}, 32'd0);
    tick();
    chk("mrst_exv_edge", {31'd0, ex_valid}, 32'd0);
    chk("mrst_wbv_edge", {31'd0, wb_valid}, 32'd0);
    idle();
    rst = 1'b0;
    tick();

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

`default_nettype wire
